// File: rtl/rom_boot_copier.sv
`timescale 1ns/1ps
// rom_boot_copier: after reset, validates the ROM header, copies the payload
// into CPU program RAM through a ready-handshaked write port, and then
// releases the CPU from reset.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start (or the automatic start after reset)
// HDR_ISSUE  | present header address 0..3 to the ROM
// HDR_CHECK  | compare the returned ROM byte with the expected magic byte
// CP_ISSUE   | present the payload address to the ROM
// CP_CAPTURE | latch the ROM byte and form the RAM address
// CP_WRITE   | hold the RAM write request until ram_ready
// DONE       | copy complete, CPU released from reset
// ERROR      | header mismatch, CPU held in reset
module rom_boot_copier #(
  parameter int                        ROM_ADDR_WIDTH = 9,
  parameter int                        RAM_ADDR_WIDTH = 16,
  parameter logic [RAM_ADDR_WIDTH-1:0] DEST_BASE      = 16'h0000,
  parameter logic [31:0]               MAGIC          = 32'h4153524D,
  parameter bit                        AUTO_START     = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  output logic                      rom_enable_out,
  input  logic [7:0]                rom_data,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]                ram_data,
  output logic                      ram_write_en,
  input  logic                      ram_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic                      cpu_reset_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_ISSUE, S_HDR_CHECK, S_CP_ISSUE,
    S_CP_CAPTURE, S_CP_WRITE, S_DONE, S_ERROR
  } state_t;

  localparam logic [ROM_ADDR_WIDTH-1:0] LAST_ADDR     = '1;
  localparam logic [ROM_ADDR_WIDTH-1:0] PAYLOAD_START = ROM_ADDR_WIDTH'(4);
  localparam logic [ROM_ADDR_WIDTH-1:0] HDR_LAST      = ROM_ADDR_WIDTH'(3);

  state_t                    state_q, state_d;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_d;
  logic [7:0]                ram_data_d;
  logic [7:0]                magic_byte;
  logic [ROM_ADDR_WIDTH-1:0] payload_off;
  // Cleared after the first clock out of reset, so auto start fires only once.
  logic                      auto_q;

  assign payload_off = rom_addr - PAYLOAD_START;

  // Select the expected header byte for the current header index (MSB first).
  always_comb begin
    magic_byte = MAGIC[31:24];
    case (rom_addr[1:0])
      2'd0: magic_byte = MAGIC[31:24];
      2'd1: magic_byte = MAGIC[23:16];
      2'd2: magic_byte = MAGIC[15:8];
      2'd3: magic_byte = MAGIC[7:0];
      default: magic_byte = MAGIC[31:24];
    endcase
  end

  // Next-state and next address/data computation.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr;
    ram_addr_d = ram_addr;
    ram_data_d = ram_data;
    case (state_q)
      S_IDLE: begin
        if (start || auto_q) begin
          state_d    = S_HDR_ISSUE;
          rom_addr_d = '0;
        end
      end
      S_HDR_ISSUE: state_d = S_HDR_CHECK;
      S_HDR_CHECK: begin
        if (rom_data != magic_byte) begin
          state_d = S_ERROR;
        end else if (rom_addr == HDR_LAST) begin
          state_d    = S_CP_ISSUE;
          rom_addr_d = PAYLOAD_START;
        end else begin
          state_d    = S_HDR_ISSUE;
          rom_addr_d = rom_addr + 1'b1;
        end
      end
      S_CP_ISSUE: state_d = S_CP_CAPTURE;
      S_CP_CAPTURE: begin
        state_d    = S_CP_WRITE;
        ram_data_d = rom_data;
        ram_addr_d = DEST_BASE + RAM_ADDR_WIDTH'(payload_off);
      end
      S_CP_WRITE: begin
        if (ram_ready) begin
          // The last ROM address ends the copy; rom_addr never wraps.
          if (rom_addr == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_CP_ISSUE;
            rom_addr_d = rom_addr + 1'b1;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_HDR_ISSUE;
          rom_addr_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; outputs are decoded from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      auto_q         <= AUTO_START;
      rom_addr       <= '0;
      ram_addr       <= '0;
      ram_data       <= '0;
      rom_enable_out <= 1'b0;
      ram_write_en   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      cpu_reset_n    <= 1'b0;
    end else begin
      state_q        <= state_d;
      auto_q         <= 1'b0;
      rom_addr       <= rom_addr_d;
      ram_addr       <= ram_addr_d;
      ram_data       <= ram_data_d;
      rom_enable_out <= state_d inside {S_HDR_ISSUE, S_HDR_CHECK, S_CP_ISSUE, S_CP_CAPTURE};
      ram_write_en   <= (state_d == S_CP_WRITE);
      busy           <= state_d inside {S_HDR_ISSUE, S_HDR_CHECK, S_CP_ISSUE,
                                        S_CP_CAPTURE, S_CP_WRITE};
      done           <= (state_d == S_DONE);
      error          <= (state_d == S_ERROR);
      cpu_reset_n    <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_rom_boot_copier.sv
`timescale 1ns/1ps
// Testbench for rom_boot_copier: scoreboard of expected RAM writes derived
// from the ROM image, plus a second instance with a wrapping destination base.
module tb_rom_boot_copier;
  localparam int AW = 9;
  localparam int RW = 16;
  localparam int ROM_SIZE = 512;
  localparam int NPAY = ROM_SIZE - 4;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, ram_ready, rand_ready;
  logic [AW-1:0] rom_addr;
  logic          rom_enable_out;
  logic [7:0]    rom_data;
  logic [RW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic          ram_write_en, busy, done, error, cpu_reset_n;

  logic          start2, ready_hi;
  logic [AW-1:0] rom_addr2;
  logic          rom_en2;
  logic [7:0]    rom_data2;
  logic [RW-1:0] ram_addr2;
  logic [7:0]    ram_data2;
  logic          wen2, busy2, done2, error2, cpu_rst2;

  logic [7:0] mem [ROM_SIZE];
  wr_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         wr_count = 0;
  int         wr2 = 0;
  logic [15:0] last_a, last_a2;

  rom_boot_copier u_dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_addr(rom_addr), .rom_enable_out(rom_enable_out), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_write_en(ram_write_en),
    .ram_ready(ram_ready), .busy(busy), .done(done), .error(error),
    .cpu_reset_n(cpu_reset_n)
  );

  rom_boot_copier #(.DEST_BASE(16'hFF00), .AUTO_START(1'b0)) u_dut_hi (
    .clk(clk), .reset(reset), .start(start2),
    .rom_addr(rom_addr2), .rom_enable_out(rom_en2), .rom_data(rom_data2),
    .ram_addr(ram_addr2), .ram_data(ram_data2), .ram_write_en(wen2),
    .ram_ready(ready_hi), .busy(busy2), .done(done2), .error(error2),
    .cpu_reset_n(cpu_rst2)
  );

  // Synchronous ROMs, output gated by enable.
  always @(posedge clk) begin
    rom_data  <= rom_enable_out ? mem[rom_addr]  : 8'h00;
    rom_data2 <= rom_en2        ? mem[rom_addr2] : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a valid header yields one write per payload byte.
  task automatic push_expected(input logic [15:0] base);
    if ({mem[0], mem[1], mem[2], mem[3]} == 32'h4153524D)
      for (int i = 0; i < NPAY; i++) exp_q.push_back('{a: base + 16'(i), d: mem[i + 4]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rom_addr"}, 32'(rom_addr), 0);
    check({tag, "_rom_en"}, 32'(rom_enable_out), 0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 0);
    check({tag, "_ram_data"}, 32'(ram_data), 0);
    check({tag, "_ram_we"}, 32'(ram_write_en), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_cpu_rst_n"}, 32'(cpu_reset_n), 0);
  endtask

  task automatic run_to_done(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      tick();
      cyc++;
    end
    check("done_reached", 32'(done), 1);
  endtask

  // ram_ready generator: constant high, or random with low runs of at most 10.
  int low_run = 0;
  always @(posedge clk) begin
    #1;
    if (rand_ready) begin
      if (low_run >= 10) ram_ready = 1'b1;
      else ram_ready = ($urandom_range(0, 1) == 1);
      low_run = ram_ready ? 0 : low_run + 1;
    end else begin
      ram_ready = 1'b1;
      low_run = 0;
    end
  end

  // Scoreboard monitor for the main instance.
  logic prev_stall = 1'b0;
  logic [15:0] prev_a;
  logic [7:0]  prev_d;
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_we_hold", 32'(ram_write_en), 1);
        check("stall_addr_hold", 32'(ram_addr), 32'(prev_a));
        check("stall_data_hold", 32'(ram_data), 32'(prev_d));
        check("stall_no_rom", 32'(rom_enable_out), 0);
      end
      if (ram_write_en && ram_ready) begin
        wr_count++;
        last_a = ram_addr;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", ram_addr, ram_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(ram_addr), 32'(e.a));
          check("wr_data", 32'(ram_data), 32'(e.d));
        end
      end
      prev_stall = ram_write_en && !ram_ready;
      prev_a = ram_addr;
      prev_d = ram_data;
    end
  end

  // Monitor for the wrapping-base instance: write k goes to 0xFF00+k mod 2^16.
  always @(negedge clk) begin
    if (reset && wen2) begin
      check("hi_wr_addr", 32'(ram_addr2), 32'(16'(16'hFF00 + 16'(wr2))));
      check("hi_wr_data", 32'(ram_data2), 32'(mem[wr2 + 4]));
      last_a2 = ram_addr2;
      wr2++;
    end
  end

  initial begin
    int cyc, base_cnt;
    ready_hi = 1'b1;
    rand_ready = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    reset = 1'b1;
    mem[0] = 8'h41; mem[1] = 8'h53; mem[2] = 8'h52; mem[3] = 8'h4D;
    for (int i = 4; i < ROM_SIZE; i++) mem[i] = 8'($urandom_range(0, 255));
    #2 reset = 1'b0;
    #1 check_reset_vals("por");
    tick(); tick();

    // Auto start with ready high; start pulses in HDR_CHECK and CP_WRITE are ignored.
    push_expected(16'h0000);
    wr_count = 0;
    reset = 1'b1;
    cyc = 0;
    while (!done && cyc < 3000) begin
      start = (cyc == 2 || cyc == 11);
      tick();
      cyc++;
    end
    start = 1'b0;
    check("auto_done_edge", 32'(cyc), 1533);
    check("auto_cpu_rst_n", 32'(cpu_reset_n), 1);
    check("auto_busy", 32'(busy), 0);
    check("auto_wr_count", 32'(wr_count), NPAY);
    check("auto_last_addr", 32'(last_a), 32'h01FB);
    check("auto_queue_empty", 32'(exp_q.size()), 0);

    // Re-copy from DONE with a randomly stalling RAM.
    tick();
    push_expected(16'h0000);
    wr_count = 0;
    rand_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("recopy_cpu_rst_n", 32'(cpu_reset_n), 0);
    check("recopy_done", 32'(done), 0);
    check("recopy_busy", 32'(busy), 1);
    run_to_done(20000, cyc);
    check("rand_wr_count", 32'(wr_count), NPAY);
    check("rand_queue_empty", 32'(exp_q.size()), 0);
    rand_ready = 1'b0;

    // Corrupt header byte 2: error 6 edges after entering HDR_ISSUE, no writes.
    mem[2] = 8'h00;
    push_expected(16'h0000);
    wr_count = 0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_busy", 32'(busy), 1);
    cyc = 0;
    while (!error && cyc < 50) begin
      tick();
      cyc++;
    end
    check("err_edge", 32'(cyc), 6);
    check("err_cpu_rst_n", 32'(cpu_reset_n), 0);
    repeat (20) tick();
    check("err_hold", 32'(error), 1);
    check("err_no_writes", 32'(wr_count), 0);

    // Repair the ROM and retry.
    mem[2] = 8'h52;
    push_expected(16'h0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("retry_error_clr", 32'(error), 0);
    run_to_done(3000, cyc);
    check("retry_wr_count", 32'(wr_count), NPAY);
    check("retry_queue_empty", 32'(exp_q.size()), 0);

    // Reset asserted while payload byte 100 is pending; copy restarts on release.
    push_expected(16'h0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(ram_write_en && ram_addr == 16'd100) && cyc < 3000) begin
      tick();
      cyc++;
    end
    check("mid_reached_100", 32'(ram_addr), 100);
    base_cnt = wr_count;
    #1 reset = 1'b0;
    #1 check_reset_vals("mid");
    exp_q.delete();
    tick(); tick();
    check("mid_no_write", 32'(wr_count), 32'(base_cnt));
    push_expected(16'h0000);
    wr_count = 0;
    reset = 1'b1;
    run_to_done(3000, cyc);
    check("mid_restart_edge", 32'(cyc), 1533);
    check("mid_wr_count", 32'(wr_count), NPAY);
    check("mid_queue_empty", 32'(exp_q.size()), 0);

    // Wrapping destination base on the second instance.
    check("hi_idle_no_auto", 32'(busy2), 0);
    wr2 = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 3000) begin
      tick();
      cyc++;
    end
    check("hi_done", 32'(done2), 1);
    check("hi_wr_count", 32'(wr2), NPAY);
    check("hi_last_addr", 32'(last_a2), 32'h00FB);
    check("hi_rom_addr_end", 32'(rom_addr2), 32'h1FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
